// File: rtl/timer_ctrl.sv
// timer_ctrl: register-mapped control stage in front of timer_dp.
// Holds the timer configuration (enable, periodic, irq_en, prescaler, 64-bit compare
// shadow), sequences the datapath through IDLE/ARM/RUN, and turns timer_dp's done
// pulse into a sticky pending flag plus a level interrupt.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   wr_en/rd_en/addr  register bus strobes and word address
//   wdata / rdata     write data / registered read data (valid with rvalid)
//   rvalid            read response, one cycle after rd_en
//   count_o           prescaled count enable to timer_dp
//   rst_counter_o     holds timer_dp's counter at 0 outside RUN
//   cmp_value_o       active compare value to timer_dp
//   done_i            expiry pulse from timer_dp
//   counter_i         timer_dp counter, read back through CNT_LO/CNT_HI
//   irq_o             pending & irq_en
module timer_ctrl #(
  parameter int PRESC_W = 16,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              count_o,
  output logic              rst_counter_o,
  output logic [63:0]       cmp_value_o,
  input  logic              done_i,
  input  logic [63:0]       counter_i,
  output logic              irq_o
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CMP_LO = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CMP_HI = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_PRESC  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CNT_LO = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_CNT_HI = ADDR_W'(6);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_enable, r_periodic, r_irq_en, r_pending;
  logic [63:0]          r_shadow, r_cmp;
  logic [PRESC_W-1:0]   r_presc, r_presc_act, r_pcnt;
  logic [31:0]          r_rdata, w_rd_mux;
  logic                 r_rvalid;

  logic w_ctrl_wr, w_start, w_done, w_wrap, w_w1c;

  assign w_ctrl_wr = wr_en && (addr == A_CTRL);
  // A start request with an empty compare is refused: enable reads back 0.
  assign w_start   = w_ctrl_wr && wdata[0] && (r_shadow != 64'd0);
  // done_i only counts while the datapath is actually running.
  assign w_done    = done_i && (r_state == S_RUN);
  assign w_wrap    = (r_state == S_RUN) && (r_pcnt == r_presc_act);
  assign w_w1c     = wr_en && (addr == A_STATUS) && wdata[0];

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    count_o       = 1'b0;
    rst_counter_o = 1'b1;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_ARM;
      S_ARM: begin
        w_state_nxt = S_RUN;
        if (w_ctrl_wr) w_state_nxt = w_start ? S_ARM : S_IDLE;
      end
      S_RUN: begin
        rst_counter_o = 1'b0;
        count_o       = w_wrap;
        // A CTRL write (restart or stop) takes priority over expiry.
        if (w_ctrl_wr)                  w_state_nxt = w_start ? S_ARM : S_IDLE;
        else if (done_i && !r_periodic) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_enable    <= 1'b0;
      r_periodic  <= 1'b0;
      r_irq_en    <= 1'b0;
      r_pending   <= 1'b0;
      r_shadow    <= '0;
      r_cmp       <= '0;
      r_presc     <= '0;
      r_presc_act <= '0;
      r_pcnt      <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_enable   <= w_start;
        r_periodic <= wdata[1];
        r_irq_en   <= wdata[2];
      end else if (w_done && !r_periodic) begin
        r_enable <= 1'b0;
      end

      if (wr_en && addr == A_CMP_LO) r_shadow[31:0]  <= wdata;
      if (wr_en && addr == A_CMP_HI) r_shadow[63:32] <= wdata;
      if (wr_en && addr == A_PRESC)  r_presc <= wdata[PRESC_W-1:0];

      // Set beats clear when expiry and W1C land together.
      r_pending <= w_done | (r_pending & ~w_w1c);

      // The live compare only moves at arm time or a period boundary.
      if (r_state == S_ARM || (w_done && r_periodic)) r_cmp <= r_shadow;

      // New PRESC values are picked up only at a wrap so a period is never cut short.
      if (r_state != S_RUN || w_wrap) begin
        r_pcnt      <= '0;
        r_presc_act <= r_presc;
      end else begin
        r_pcnt <= r_pcnt + PRESC_W'(1);
      end

      r_rvalid <= rd_en;
      r_rdata  <= rd_en ? w_rd_mux : 32'd0;
    end
  end

  // Read mux samples the registers before this cycle's write lands.
  always_comb begin
    w_rd_mux = 32'd0;
    case (addr)
      A_CTRL:   w_rd_mux = {29'd0, r_irq_en, r_periodic, r_enable};
      A_CMP_LO: w_rd_mux = r_shadow[31:0];
      A_CMP_HI: w_rd_mux = r_shadow[63:32];
      A_STATUS: w_rd_mux = {31'd0, r_pending};
      A_PRESC:  w_rd_mux = 32'(r_presc);
      A_CNT_LO: w_rd_mux = counter_i[31:0];
      A_CNT_HI: w_rd_mux = counter_i[63:32];
      default:  w_rd_mux = 32'd0;
    endcase
  end

  assign rdata       = r_rdata;
  assign rvalid      = r_rvalid;
  assign cmp_value_o = r_cmp;
  assign irq_o       = r_pending & r_irq_en;

endmodule
